// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
// ------------------------------------------------------------------
// Splits one valid/ready input stream across eight output channels.
// Words are dealt round-robin, BURST words per channel, and the
// pointer moves only to channels enabled in chan_en. A one-word
// output register sits between the input and the channels. It drives
// the demux select, a one-hot valid and a shared data bus.
//
// Handshake rule: on every port, a word moves on a rising clk edge
// exactly when its valid and its ready are both high. A held word
// (out_valid != 0) keeps out_data and sel stable until the selected
// channel takes it.
//
// Parameters:
//   DW    - data word width
//   BURST - words delivered to a channel before the pointer advances
//           (1..256)
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   en          - dispatch enable
//   chan_en     - per-channel enable mask
//   in_valid/in_data/in_ready - input stream
//   out_ready   - per-channel ready
//   out_valid   - one-hot valid; only bit sel can be set
//   out_data    - registered word, shared by all channels
//   sel         - current channel index (demux select)
//   busy        - high while in RUN or DRAIN
//   stat_cnt    - only with DEMUX_RR_STATS_EN: eight saturating 16-bit
//                 per-channel acceptance counters, channel i at
//                 [16i+15:16i]
//
// Optional build macro: DEMUX_RR_STATS_EN adds stat_cnt.
// The FSM state is visible as state_q for debug access.
// ------------------------------------------------------------------
module demux_rr_dispatcher #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [7:0]    chan_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [7:0]    out_ready,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic          busy
`ifdef DEMUX_RR_STATS_EN
  ,
  output logic [127:0]  stat_cnt
`endif
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic [DW-1:0]   data_q;
  logic            accept;
  logic            load;
  logic            last_beat;
  logic [2:0]      nxt;

  // First enabled channel after cur, scanning cur+1 .. cur+8 (wrapping).
  // The last probe is cur itself, so a lone enabled channel maps to
  // itself. With an empty mask the pointer stays put.
  function automatic logic [2:0] nxt_sel(input logic [2:0] cur,
                                         input logic [7:0] mask);
    logic [2:0] res;
    logic [2:0] j;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      j = cur + 3'(k);
      if (!found && mask[j]) begin
        res   = j;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign nxt       = nxt_sel(sel_q, chan_en);
  assign accept    = full_q && out_ready[sel_q];
  assign in_ready  = (state_q == RUN) && chan_en[sel_q] &&
                     (!full_q || out_ready[sel_q]);
  assign load      = in_valid && in_ready;
  assign last_beat = (cnt_q == CW'(BURST - 1));
  assign full_d    = load || (full_q && !accept);

  assign out_valid = full_q ? (8'b1 << sel_q) : 8'h00;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && (chan_en != 8'h00)) begin
          state_d = RUN;
          sel_d   = chan_en[sel_q] ? sel_q : nxt;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // A held word still goes to sel after its channel is
          // disabled. Then the pointer moves on as if the burst ended.
          if (last_beat || !chan_en[sel_q]) begin
            cnt_d = '0;
            sel_d = nxt;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (!full_q && !chan_en[sel_q]) begin
          sel_d = nxt;
          cnt_d = '0;
        end
        // A word can be loaded in the cycle en falls, so DRAIN depends on
        // whether the register is full after this edge.
        if (!en || (chan_en == 8'h00)) begin
          state_d = full_d ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (accept || !full_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The output register loads and accepts in the same cycle. It stays
  // full and holds the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (load) begin
        data_q <= in_data;
      end
    end
  end

`ifdef DEMUX_RR_STATS_EN
  logic [15:0] stat_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        stat_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept && (sel_q == 3'(i)) && (stat_q[i] != 16'hFFFF)) begin
          stat_q[i] <= stat_q[i] + 16'h0001;
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      stat_cnt[16*i +: 16] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher
// Directed test bench for demux_rr_dispatcher (DW=8, BURST=4). Inputs
// change 1 time unit after a rising edge. Outputs are checked on the
// falling edge, or 1 unit after a rising edge. The expected
// {channel, word} for each input is queued when the input is accepted.
// It is popped when a channel accepts the output word.
module tb_demux_rr_dispatcher;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [7:0]    chan_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    out_ready;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic          busy;
`ifdef DEMUX_RR_STATS_EN
  logic [127:0]  stat_cnt;
`endif

  demux_rr_dispatcher #(.DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .chan_en   (chan_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
`ifdef DEMUX_RR_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [DW+2:0] exp_q[$];
  int            chk_cnt  = 0;
  int            pass_cnt = 0;
  logic          track    = 1'b0;
  logic [7:0]    seen     = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    logic [DW+2:0] e;
    if (rst_n) begin
      if (track) seen = seen | out_valid;
      if (out_valid !== 8'h00) chk("out_valid_onehot", out_valid, 8'b1 << sel);
      if ((out_valid & out_ready) != 8'h00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_chan", 32'(sel), 32'(e[DW+2:DW]));
          chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one word and hold it until the handshake. Return 1 unit
  // after the accepting edge, with in_valid low.
  task automatic send(input logic [DW-1:0] d, input logic [2:0] ch,
                      input bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      chk("send_timeout", 1, 0);
    end else if (push) begin
      exp_q.push_back({ch, d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid != 8'h00) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int t1;
    rst_n     = 1'b0;
    en        = 1'b0;
    chan_en   = 8'h00;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 8'h00;
    #12;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
`ifdef DEMUX_RR_STATS_EN
    chk("rst_stat_lo", stat_cnt[31:0], 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // All channels enabled, continuous stream of 32 words.
    en        = 1'b1;
    chan_en   = 8'hFF;
    out_ready = 8'hFF;
    send(8'h00, 3'd0, 1'b1);
    t0 = cyc;
    chk("first_latency_valid", 32'(out_valid), 32'h01);
    chk("first_latency_data", 32'(out_data), 32'h00);
    for (int w = 1; w < 32; w++) send(DW'(w), 3'(w / 4), 1'b1);
    t1 = cyc;
    chk("stream_rate", 32'(t1 - t0), 31);
    wait_drain();
    chk("sel_wrap", 32'(sel), 0);

    // Sparse mask: channels 0, 2, 7.
    chan_en = 8'b1000_0101;
    track   = 1'b1;
    for (int w = 0; w < 12; w++) begin
      logic [2:0] ch;
      ch = (w < 4) ? 3'd0 : ((w < 8) ? 3'd2 : 3'd7);
      send(DW'(8'h40 + w), ch, 1'b1);
    end
    wait_drain();
    track = 1'b0;
    chk("sparse_unused_quiet", 32'(seen & 8'h7A), 0);
    chk("sparse_used_seen", 32'(seen & 8'h85), 32'h85);
    chk("sparse_sel_wrap", 32'(sel), 0);

    // Backpressure on channel 0.
    chan_en   = 8'hFF;
    out_ready = 8'hFE;
    send(8'h11, 3'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_data_stable", 32'(out_data), 32'h11);
      chk("bp_sel_stable", 32'(sel), 0);
      if (i == 4) out_ready = 8'hFF;
      step();
    end
    chk("bp_delivered", 32'(out_valid), 0);
    chk("bp_no_loss", exp_q.size(), 0);

    // Mask change while 0xA5 is held for channel 0.
    out_ready = 8'hFE;
    send(8'hA5, 3'd0, 1'b1);
    chan_en = 8'hFE;
    step();
    chk("mask_sel_hold", 32'(sel), 0);
    chk("mask_data_hold", 32'(out_data), 32'hA5);
    chk("mask_in_ready", 32'(in_ready), 0);
    out_ready = 8'hFF;
    step();
    chk("mask_sel_moved", 32'(sel), 1);
    chk("mask_reg_empty", 32'(out_valid), 0);
    for (int w = 0; w < 5; w++) send(DW'(8'hB0 + w), (w < 4) ? 3'd1 : 3'd2, 1'b1);
    wait_drain();

    // Stop with a word held and all channels stalled.
    out_ready = 8'h00;
    send(8'h3C, 3'd2, 1'b1);
    en = 1'b0;
    step();
    in_valid = 1'b1;
    #1;
    chk("drain_state", 32'(dut.state_q), 2);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_in_ready", 32'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 8'hFF;
    step();
    chk("idle_state", 32'(dut.state_q), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("drain_no_loss", exp_q.size(), 0);

    // Reset while a word is held; that word is discarded.
    en        = 1'b1;
    chan_en   = 8'hFF;
    out_ready = 8'h00;
    send(8'h77, 3'd2, 1'b0);
    chk("pre_rst_full", 32'(out_valid), 32'h04);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_sel", 32'(sel), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    step();
    en        = 1'b0;
    out_ready = 8'hFF;
    rst_n     = 1'b1;
    step();

`ifdef DEMUX_RR_STATS_EN
    en      = 1'b1;
    chan_en = 8'h01;
    for (int w = 0; w < 70000; w++) send(DW'(w), 3'd0, 1'b1);
    wait_drain();
    chk("stat_ch0_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
    for (int c = 1; c < 8; c++) chk("stat_other_zero", 32'(stat_cnt[16*c +: 16]), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
